pifo_calendar_arbiter: RTL and testbench
========================================

PIFO_CALENDAR_ARBITER -- requirements
Module: pifo_calendar_arbiter

Interface
REQ-001 SHALL have parameter PIFO_CALENDAR_SIZE, default 1024, meaning calendar slot count.
REQ-002 SHALL have parameter PIFO_CALENDAR_INDEX_WIDTH, default 10, meaning CPU slot address width.
REQ-003 SHALL have parameter PIFO_ROOT_WIDTH, default 32, meaning element width.
REQ-004 SHALL have parameter CPU_STARVE_LIMIT, default 16, meaning maximum consecutive cycles a pending CPU request loses arbitration.
REQ-005 SHALL have these ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enq_valid / enq_ready / enq_data  in / out / in  1 / 1 / PIFO_ROOT_WIDTH  insert request handshake and element.
- deq_req / deq_ack / deq_data  in / out / out  1 / 1 / PIFO_ROOT_WIDTH  pop request, pop completion and popped element.
- cpu_req / cpu_we / cpu_addr / cpu_wdata  in  1 / 1 / INDEX / ROOT  CPU access request.
- cpu_done / cpu_rdata  out  1 / ROOT  CPU access completion and read data.
- cal_insert_en / cal_pop_en / cal_info  out  1 / 1 / ROOT  calendar insert and pop strobes and insert element.
- cal_cpu_wr_valid / cal_cpu_rd_valid / cal_cpu_addr / cal_cpu_wdata  out  1 / 1 / INDEX / ROOT  calendar CPU channel.
- cal_top / cal_cpu_wr_result_valid / cal_cpu_rd_result_valid / cal_cpu_rd_result  in  ROOT / 1 / 1 / ROOT  calendar responses.
- occupancy / full / empty  out  INDEX+1 / 1 / 1  tracked element count and flags.

Function
REQ-006 SHALL assert at most one of cal_insert_en and cal_pop_en in any cycle.
REQ-007 SHALL implement states IDLE, CPU_WR_WAIT and CPU_RD_WAIT.
REQ-008 In IDLE, SHALL grant at most one request per cycle: pop, else insert, else CPU.
REQ-009 When deq_req and enq_valid are both eligible, SHALL alternate the grant between them, starting with pop after reset.
REQ-010 SHALL make pop eligible only when empty=0, and insert eligible only when full=0.
REQ-011 SHALL drive enq_ready=1 only in an IDLE cycle where insert is granted, and SHALL pulse cal_insert_en with cal_info=enq_data in that same cycle.
REQ-012 On a pop grant, SHALL pulse cal_pop_en, register cal_top, and assert deq_ack for one cycle on the next cycle with deq_data holding the registered value.
REQ-013 deq_req SHALL be level-sensitive: each grant serves exactly one pop.
REQ-014 On a CPU write grant, SHALL pulse cal_cpu_wr_valid with the addr/wdata, suppress insert and pop, and enter CPU_WR_WAIT.
REQ-015 In CPU_WR_WAIT, SHALL return to IDLE on cal_cpu_wr_result_valid and pulse cpu_done for one cycle.
REQ-016 On a CPU read grant, SHALL pulse cal_cpu_rd_valid and enter CPU_RD_WAIT.
REQ-017 In CPU_RD_WAIT, on cal_cpu_rd_result_valid, SHALL capture cpu_rdata, pulse cpu_done and return to IDLE; insert and pop remain eligible in CPU_RD_WAIT.
REQ-018 On each completed insert, occupancy SHALL increment by 1; on each completed pop, it SHALL decrement by 1; occupancy SHALL never wrap.
REQ-019 full SHALL be 1 when occupancy >= PIFO_CALENDAR_SIZE-2; empty SHALL be 1 when occupancy == 0.
REQ-020 CPU accesses SHALL NOT change occupancy.
REQ-021 A request arriving in CPU_WR_WAIT SHALL be held, not dropped.

Reset
REQ-022 While rst=1, SHALL force state IDLE, occupancy 0, empty 1, full 0, the alternation pointer to pop, and the starvation counter to 0.
REQ-023 While rst=1, SHALL drive all strobes, enq_ready, deq_ack and cpu_done to 0, and deq_data and cpu_rdata to 0.
REQ-024 Reset asserted mid-CPU-access SHALL abandon the access with no cpu_done.

Configuration
REQ-025 Macro PIFO_ARB_CPU_STARVE_GUARD_EN SHALL control CPU starvation protection.
- Defined: a counter SHALL increment each IDLE cycle in which cpu_req is pending but not granted; at CPU_STARVE_LIMIT the CPU SHALL be granted ahead of pop and insert, and the counter SHALL clear on any CPU grant.
- Undefined: CPU SHALL be the lowest priority with no counter logic.

Verification
REQ-026 Reset, then enq_valid=1 with data 0x0000_1005 for 3 cycles -> 3 cal_insert_en pulses, occupancy=3, empty=0.
REQ-027 deq_req and enq_valid held together with occupancy=2 -> grants alternate pop, insert, pop, insert; cal_insert_en and cal_pop_en never high together.
REQ-028 deq_req with occupancy=0 -> no cal_pop_en and no deq_ack; one insert, then deq_ack 1 cycle after cal_pop_en with deq_data equal to the pre-pop cal_top.
REQ-029 Fill to occupancy=1022 -> full=1 and enq_ready stays 0; one pop -> full=0.
REQ-030 CPU write addr 5, data 0xABCD_0001, while inserts are pending -> no insert until cal_cpu_wr_result_valid, then cpu_done 1 cycle and inserts resume.
REQ-031 With the guard macro defined and continuous pop/insert traffic -> the pending CPU read is granted within 16 cycles; with it undefined -> the CPU read is not granted until traffic stops.

Source files
------------

// File: rtl/pifo_calendar_arbiter_if.sv
// ---------------------------------------------------------------------------
// pifo_calendar_arbiter_if : request/response bundle between clients, the
// arbiter and the PIFO calendar.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pifo_calendar_arbiter_if #(
    parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
    parameter int PIFO_ROOT_WIDTH           = 32
);
    logic                                 enq_valid;
    logic                                 enq_ready;
    logic [PIFO_ROOT_WIDTH-1:0]           enq_data;
    logic                                 deq_req;
    logic                                 deq_ack;
    logic [PIFO_ROOT_WIDTH-1:0]           deq_data;
    logic                                 cpu_req;
    logic                                 cpu_we;
    logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_addr;
    logic [PIFO_ROOT_WIDTH-1:0]           cpu_wdata;
    logic                                 cpu_done;
    logic [PIFO_ROOT_WIDTH-1:0]           cpu_rdata;
    logic                                 cal_insert_en;
    logic                                 cal_pop_en;
    logic [PIFO_ROOT_WIDTH-1:0]           cal_info;
    logic                                 cal_cpu_wr_valid;
    logic                                 cal_cpu_rd_valid;
    logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cal_cpu_addr;
    logic [PIFO_ROOT_WIDTH-1:0]           cal_cpu_wdata;
    logic [PIFO_ROOT_WIDTH-1:0]           cal_top;
    logic                                 cal_cpu_wr_result_valid;
    logic                                 cal_cpu_rd_result_valid;
    logic [PIFO_ROOT_WIDTH-1:0]           cal_cpu_rd_result;
    logic [PIFO_CALENDAR_INDEX_WIDTH:0]   occupancy;
    logic                                 full;
    logic                                 empty;

    // Client/calendar environment side
    modport master (
        output enq_valid, enq_data, deq_req, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               cal_top, cal_cpu_wr_result_valid, cal_cpu_rd_result_valid, cal_cpu_rd_result,
        input  enq_ready, deq_ack, deq_data, cpu_done, cpu_rdata,
               cal_insert_en, cal_pop_en, cal_info, cal_cpu_wr_valid, cal_cpu_rd_valid,
               cal_cpu_addr, cal_cpu_wdata, occupancy, full, empty
    );

    // Arbiter side
    modport slave (
        input  enq_valid, enq_data, deq_req, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               cal_top, cal_cpu_wr_result_valid, cal_cpu_rd_result_valid, cal_cpu_rd_result,
        output enq_ready, deq_ack, deq_data, cpu_done, cpu_rdata,
               cal_insert_en, cal_pop_en, cal_info, cal_cpu_wr_valid, cal_cpu_rd_valid,
               cal_cpu_addr, cal_cpu_wdata, occupancy, full, empty
    );
endinterface

`default_nettype wire

// File: rtl/pifo_calendar_arbiter.sv
// ---------------------------------------------------------------------------
// pifo_calendar_arbiter : arbitrates insert, pop and CPU access to a PIFO
// calendar and tracks occupancy.  Optional macro PIFO_ARB_CPU_STARVE_GUARD_EN
// enables CPU starvation protection.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pifo_calendar_arbiter #(
    parameter int PIFO_CALENDAR_SIZE        = 1024,
    parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
    parameter int PIFO_ROOT_WIDTH           = 32,
    parameter int CPU_STARVE_LIMIT          = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    pifo_calendar_arbiter_if.slave   bus
);
    localparam int IW = PIFO_CALENDAR_INDEX_WIDTH;
    localparam int RW = PIFO_ROOT_WIDTH;
    localparam logic [IW:0] FULL_THRESH = (IW+1)'(PIFO_CALENDAR_SIZE - 2);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CPU_WR_WAIT = 2'd1,
        CPU_RD_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW:0]     occ_q, occ_d;
    logic            alt_q, alt_d;      // 0: pop wins the next pop/insert tie
    logic            deq_ack_q, deq_ack_d;
    logic [RW-1:0]   deq_data_q, deq_data_d;
    logic            cpu_done_q, cpu_done_d;
    logic [RW-1:0]   cpu_rdata_q, cpu_rdata_d;

    logic            full_w, empty_w, arb_ok_w, cpu_force_w;
    logic            pop_elig_w, ins_elig_w, pop_gnt_w, ins_gnt_w, cpu_gnt_w;

    if (CPU_STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("CPU_STARVE_LIMIT must be at least 1");
    end

`ifdef PIFO_ARB_CPU_STARVE_GUARD_EN
    localparam int SW = $clog2(CPU_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    assign cpu_force_w = !rst && (state_q == IDLE) && bus.cpu_req && (starve_q >= STARVE_MAX);

    always_comb begin
        starve_d = starve_q;
        if (cpu_gnt_w)
            starve_d = '0;
        else if ((state_q == IDLE) && bus.cpu_req && (starve_q < STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign cpu_force_w = 1'b0;
`endif

    assign full_w   = (occ_q >= FULL_THRESH);
    assign empty_w  = (occ_q == '0);
    // A pending CPU write blocks the calendar; a pending read does not.
    assign arb_ok_w = !rst && (state_q != CPU_WR_WAIT);

    assign pop_elig_w = arb_ok_w && bus.deq_req   && !empty_w && !cpu_force_w;
    assign ins_elig_w = arb_ok_w && bus.enq_valid && !full_w  && !cpu_force_w;
    assign pop_gnt_w  = pop_elig_w && (!ins_elig_w || !alt_q);
    assign ins_gnt_w  = ins_elig_w && (!pop_elig_w ||  alt_q);
    assign cpu_gnt_w  = !rst && (state_q == IDLE) && bus.cpu_req && !pop_elig_w && !ins_elig_w;

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        alt_d       = alt_q;
        deq_ack_d   = pop_gnt_w;
        deq_data_d  = deq_data_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;

        if (pop_elig_w && ins_elig_w)
            alt_d = !alt_q;
        if (ins_gnt_w)
            occ_d = occ_q + (IW+1)'(1);
        else if (pop_gnt_w)
            occ_d = occ_q - (IW+1)'(1);
        if (pop_gnt_w)
            deq_data_d = bus.cal_top;

        case (state_q)
            IDLE: begin
                if (cpu_gnt_w)
                    state_d = bus.cpu_we ? CPU_WR_WAIT : CPU_RD_WAIT;
            end
            CPU_WR_WAIT: begin
                if (bus.cal_cpu_wr_result_valid) begin
                    state_d    = IDLE;
                    cpu_done_d = 1'b1;
                end
            end
            CPU_RD_WAIT: begin
                if (bus.cal_cpu_rd_result_valid) begin
                    state_d     = IDLE;
                    cpu_done_d  = 1'b1;
                    cpu_rdata_d = bus.cal_cpu_rd_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            alt_q       <= 1'b0;
            deq_ack_q   <= 1'b0;
            deq_data_q  <= '0;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            alt_q       <= alt_d;
            deq_ack_q   <= deq_ack_d;
            deq_data_q  <= deq_data_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign bus.enq_ready        = ins_gnt_w;
    assign bus.cal_insert_en    = ins_gnt_w;
    assign bus.cal_info         = bus.enq_data;
    assign bus.cal_pop_en       = pop_gnt_w;
    assign bus.deq_ack          = deq_ack_q;
    assign bus.deq_data         = deq_data_q;
    assign bus.cal_cpu_wr_valid = cpu_gnt_w &&  bus.cpu_we;
    assign bus.cal_cpu_rd_valid = cpu_gnt_w && !bus.cpu_we;
    assign bus.cal_cpu_addr     = bus.cpu_addr;
    assign bus.cal_cpu_wdata    = bus.cpu_wdata;
    assign bus.cpu_done         = cpu_done_q;
    assign bus.cpu_rdata        = cpu_rdata_q;
    assign bus.occupancy        = occ_q;
    assign bus.full             = full_w;
    assign bus.empty            = empty_w;

endmodule

`default_nettype wire

// File: tb/tb_pifo_calendar_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pifo_calendar_arbiter : directed self-checking bench for the PIFO
// calendar arbiter.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pifo_calendar_arbiter;
    localparam int STARVE = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pifo_calendar_arbiter_if bus ();

    pifo_calendar_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.enq_valid = 0; bus.enq_data = '0; bus.deq_req = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cal_top = '0; bus.cal_cpu_wr_result_valid = 0;
        bus.cal_cpu_rd_result_valid = 0; bus.cal_cpu_rd_result = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic insert_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.enq_valid = 1; bus.enq_data = 32'h100 + k;
        end
        @(negedge clk);
        bus.enq_valid = 0;
    endtask

    initial begin
        int  cnt;
        int  both;
        int  gi;
        bit  gnt;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // Requests during reset must produce nothing
        bus.enq_valid = 1; bus.deq_req = 1; bus.cpu_req = 1; #1;
        check("rst_enq_ready", bus.enq_ready, 0);
        check("rst_ins_en", bus.cal_insert_en, 0);
        check("rst_pop_en", bus.cal_pop_en, 0);
        check("rst_cpu_rd", bus.cal_cpu_rd_valid, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_deq_ack", bus.deq_ack, 0);
        check("rst_deq_data", bus.deq_data, 0);
        check("rst_cpu_done", bus.cpu_done, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // Three back-to-back inserts
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.enq_valid = 1; bus.enq_data = 32'h0000_1005; #1;
            check("ins3_en", bus.cal_insert_en, 1);
            check("ins3_ready", bus.enq_ready, 1);
            check("ins3_info", bus.cal_info, 32'h0000_1005);
        end
        @(negedge clk);
        bus.enq_valid = 0; #1;
        check("ins3_occ", bus.occupancy, 3);
        check("ins3_empty", bus.empty, 0);

        // Pop/insert alternation starting with pop
        do_reset();
        insert_n(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.deq_req = 1; bus.enq_valid = 1; bus.enq_data = 32'h200 + i; #1;
            check("alt_pop", bus.cal_pop_en, (i % 2 == 0) ? 1 : 0);
            check("alt_ins", bus.cal_insert_en, (i % 2 == 0) ? 0 : 1);
        end
        @(negedge clk);
        bus.deq_req = 0; bus.enq_valid = 0; #1;
        check("alt_occ", bus.occupancy, 2);

        // Pop on empty, then a real pop with registered top
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.deq_req = 1; #1;
            check("emp_pop_en", bus.cal_pop_en, 0);
            check("emp_deq_ack", bus.deq_ack, 0);
        end
        @(negedge clk);
        bus.deq_req = 0;
        insert_n(1);
        bus.cal_top = 32'hDEAD_BEEF; bus.deq_req = 1; #1;
        check("pop_en", bus.cal_pop_en, 1);
        @(negedge clk);
        bus.deq_req = 0; bus.cal_top = 32'h5555_5555; #1;
        check("pop_ack", bus.deq_ack, 1);
        check("pop_data", bus.deq_data, 32'hDEAD_BEEF);
        check("pop_empty", bus.empty, 1);
        @(negedge clk); #1;
        check("pop_ack_pulse", bus.deq_ack, 0);

        // Fill to the full threshold
        do_reset();
        cnt = 0;
        for (int i = 0; i < 1030; i++) begin
            @(negedge clk);
            bus.enq_valid = 1; #1;
            if (bus.cal_insert_en) cnt++;
        end
        check("fill_count", cnt, 1022);
        check("fill_occ", bus.occupancy, 1022);
        check("fill_full", bus.full, 1);
        check("fill_ready", bus.enq_ready, 0);
        @(negedge clk);
        bus.enq_valid = 0; bus.deq_req = 1; #1;
        check("fill_pop_en", bus.cal_pop_en, 1);
        @(negedge clk);
        bus.deq_req = 0; #1;
        check("fill_unfull", bus.full, 0);
        check("fill_occ2", bus.occupancy, 1021);

        // CPU write blocks inserts until its result returns
        do_reset();
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 10'd5; bus.cpu_wdata = 32'hABCD_0001; #1;
        check("wr_valid", bus.cal_cpu_wr_valid, 1);
        check("wr_addr", bus.cal_cpu_addr, 5);
        check("wr_wdata", bus.cal_cpu_wdata, 32'hABCD_0001);
        check("wr_no_rd", bus.cal_cpu_rd_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.cpu_req = 0; bus.enq_valid = 1; bus.enq_data = 32'h77; #1;
            check("wr_wait_ins", bus.cal_insert_en, 0);
        end
        @(negedge clk);
        bus.cal_cpu_wr_result_valid = 1; #1;
        check("wr_res_ins", bus.cal_insert_en, 0);
        check("wr_res_done", bus.cpu_done, 0);
        @(negedge clk);
        bus.cal_cpu_wr_result_valid = 0; #1;
        check("wr_done", bus.cpu_done, 1);
        check("wr_resume", bus.cal_insert_en, 1);
        @(negedge clk); #1;
        check("wr_done_pulse", bus.cpu_done, 0);
        @(negedge clk);
        bus.enq_valid = 0; #1;
        check("wr_occ", bus.occupancy, 2);

        // CPU read: calendar traffic continues while waiting
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'd9; #1;
        check("rd_valid", bus.cal_cpu_rd_valid, 1);
        @(negedge clk);
        bus.cpu_req = 0; bus.enq_valid = 1; #1;
        check("rd_wait_ins", bus.cal_insert_en, 1);
        @(negedge clk);
        bus.enq_valid = 0; bus.cal_cpu_rd_result_valid = 1; bus.cal_cpu_rd_result = 32'h1234_5678; #1;
        check("rd_res_done", bus.cpu_done, 0);
        @(negedge clk);
        bus.cal_cpu_rd_result_valid = 0; #1;
        check("rd_done", bus.cpu_done, 1);
        check("rd_rdata", bus.cpu_rdata, 32'h1234_5678);
        check("rd_occ", bus.occupancy, 3);

        // CPU read under continuous pop/insert traffic
        do_reset();
        insert_n(2);
        gnt = 0; gi = -1; both = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.deq_req = 1; bus.enq_valid = 1; bus.cpu_req = !gnt; bus.cpu_we = 0; #1;
            if (bus.cal_pop_en && bus.cal_insert_en) both++;
            if (!gnt && bus.cal_cpu_rd_valid) begin
                gnt = 1; gi = i;
            end
        end
        check("starve_both", both, 0);
`ifdef PIFO_ARB_CPU_STARVE_GUARD_EN
        check("starve_granted", gnt, 1);
        check("starve_in_limit", (gi >= 0 && gi <= STARVE) ? 1 : 0, 1);
`else
        check("starve_held", gnt, 0);
        @(negedge clk);
        bus.deq_req = 0; bus.enq_valid = 0; bus.cpu_req = 1; #1;
        check("starve_after", bus.cal_cpu_rd_valid, 1);
`endif
        @(negedge clk);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
